cla_add_seq: RTL and testbench
==============================

Name: cla_add_seq

Overview:
- Sequencer for a multi-operand modular adder, for SHA-256 round sums such as T1 = h + Σ1 + Ch + K + W.
- Operands arrive on a valid/ready stream. The block reuses a single 8-bit carry-lookahead byte slice, one byte per cycle, with a registered carry between bytes.
- It trades latency for area. It sits between the round-function logic and the working-variable registers of the miner core.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8.
- CNT_W, 4, width of the operand counter; counts saturate at 2**CNT_W-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  operand available
- op_ready  out  1  block accepts operand this cycle
- op_data  in  WIDTH  operand
- op_last  in  1  final operand of the current sum
- sum_valid  out  1  result available
- sum_ready  in  1  consumer accepts result
- sum_data  out  WIDTH  sum mod 2**WIDTH
- sum_count  out  CNT_W  number of operands summed (saturating)
- busy  out  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high, and is sampled on the rising edge of clock.
- Reset values: op_ready=1, sum_valid=0, sum_data=0, sum_count=0, busy=0. Accumulator, carry register and byte index are all 0.
- NB = WIDTH/8. Transfers occur on valid&&ready.
- FSM states: IDLE, WAIT, ADD, DONE.
- IDLE (op_ready=1):
  - An accepted operand loads the accumulator directly; no add is performed. count=1.
  - If op_last, go to DONE; otherwise go to WAIT.
- WAIT (op_ready=1):
  - An accepted operand is latched into the operand register; op_last is latched into last_pend.
  - count increments, saturating. Byte index=0, carry=0. Go to ADD.
- ADD (op_ready=0), one cycle per byte i, i=0..NB-1:
  - acc[8i+7:8i] <= slice(acc byte i, opnd byte i, carry).
  - carry <= slice carry-out.
  - After byte NB-1, the final carry-out is discarded (modular arithmetic). Go to DONE if last_pend, else WAIT.
- DONE:
  - sum_valid=1; sum_data and sum_count are held stable.
  - On sum_ready: sum_valid drops next cycle, the accumulator clears, go to IDLE.
  - op_ready=0 while in DONE. There is no cut-through.
- Latency:
  - N=1: sum_valid is asserted the cycle after the accept.
  - N>=2: sum_valid is asserted NB cycles after the last operand is accepted.
  - Throughput: one operand per NB+1 cycles.
- Gaps in op_valid during WAIT are allowed indefinitely; state is held.
- op_last accepted in IDLE ends the sum immediately.
- op_data is sampled only on the accept cycle and need not stay stable afterwards.
- Reset asserted mid-ADD or in DONE aborts the operation. The partial sum is lost and all outputs return to reset values.
- sum_count saturates at 2**CNT_W-1; the sum itself remains correct.

Optional Feature:
- Macro: CLA_ADD_SEQ_OVF_EN.
- When defined:
  - Adds output port sum_ovf (1 bit).
  - sum_ovf is a sticky OR of every discarded final carry within the current sum.
  - It is valid with sum_valid, and clears on reset and on result handoff.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cla_add_pkg holds:
  - the state enum (IDLE, WAIT, ADD, DONE);
  - BYTE_W=8;
  - the SHA-256 constants used by benches (H0 initial values, K table).
- One sub-module, cla_byte_slice: purely combinational 8-bit carry-lookahead adder with ports a[7:0], b[7:0], cin → s[7:0], cout.
- cla_add_seq instantiates exactly one cla_byte_slice.
- Byte-lane muxing, the carry register and the FSM stay in cla_add_seq.

Test Plan:
- Single operand 0xDEADBEEF with op_last → sum_valid 1 cycle after accept, sum_data=0xDEADBEEF, sum_count=1.
- 0x000000FF then 0x00000001 (last) → sum_data=0x00000100, showing carry propagating across bytes; sum_valid asserted 4 cycles after the second accept.
- 0x6A09E667 + 0xBB67AE85 (last) → sum_data=0x257194EC, final carry discarded. With CLA_ADD_SEQ_OVF_EN: sum_ovf=1.
- Five operands 1,2,3,4,5 with op_valid gaps of 0–3 cycles → sum_data=0x0000000F, sum_count=5. op_ready must be low throughout every ADD phase.
- Hold sum_ready=0 for 10 cycles in DONE → sum_valid and sum_data stay stable and op_ready=0. Then raise sum_ready → next cycle IDLE, busy=0.
- Assert reset during ADD byte 2 of a two-operand sum → next cycle all outputs are at reset values. A fresh single operand 0x12345678 then yields 0x12345678.

Source files
------------

// File: rtl/cla_add_pkg.sv
// ============================================================================
// cla_add_pkg : shared types and constants for the byte-serial CLA adder
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cla_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [0:7][31:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

`default_nettype wire

// File: rtl/cla_byte_slice.sv
// ============================================================================
// cla_byte_slice : combinational 8-bit carry-lookahead adder (two 4-bit groups)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module cla_byte_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Carries c1..c4 of one 4-bit group, fully expanded from generate/propagate.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [3:0] w_c_lo;
  logic [3:0] w_c_hi;
  logic [3:0] w_grp_lo;
  logic       w_c4;
  logic [7:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Group generate/propagate lets the upper group start without the lower ripple.
  assign w_grp_lo = cla4(w_g[3:0], w_p[3:0], 1'b0);
  assign w_c4     = w_grp_lo[3] | ((&w_p[3:0]) & cin);
  assign w_c_lo   = cla4(w_g[3:0], w_p[3:0], cin);
  assign w_c_hi   = cla4(w_g[7:4], w_p[7:4], w_c4);

  assign w_c  = {w_c_hi[2:0], w_c4, w_c_lo[2:0], cin};
  assign s    = w_p ^ w_c;
  assign cout = w_c_hi[3];

endmodule

`default_nettype wire

// File: rtl/cla_add_seq.sv
// ============================================================================
// cla_add_seq : multi-operand modular adder, one byte per cycle through a
//               single CLA slice. Optional sum_ovf_o via CLA_ADD_SEQ_OVF_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cla_add_seq
  import cla_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_data_i,
  input  logic             op_last_i,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic [WIDTH-1:0] sum_data_o,
  output logic [CNT_W-1:0] sum_count_o,
  output logic             busy_o
`ifdef CLA_ADD_SEQ_OVF_EN
  ,
  output logic             sum_ovf_o
`endif
);

  localparam int NB    = WIDTH / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_e                       state_q, state_d;
  logic [NB-1:0][BYTE_W-1:0]    acc_q, acc_d;
  logic [NB-1:0][BYTE_W-1:0]    opnd_q, opnd_d;
  logic                         carry_q, carry_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         last_q, last_d;
`ifdef CLA_ADD_SEQ_OVF_EN
  logic                         ovf_q, ovf_d;
`endif

  logic              w_accept;
  logic [BYTE_W-1:0] w_slice_s;
  logic              w_slice_cout;

  cla_byte_slice u_slice (
    .a    (acc_q[idx_q]),
    .b    (opnd_q[idx_q]),
    .cin  (carry_q),
    .s    (w_slice_s),
    .cout (w_slice_cout)
  );

  assign op_ready_o  = (state_q == IDLE) || (state_q == WAIT);
  assign sum_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_data_o  = acc_q;
  assign sum_count_o = cnt_q;
  assign w_accept    = op_valid_i && op_ready_o;
`ifdef CLA_ADD_SEQ_OVF_EN
  assign sum_ovf_o   = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef CLA_ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        // First operand needs no add: it seeds the accumulator.
        if (w_accept) begin
          acc_d   = op_data_i;
          cnt_d   = CNT_W'(1);
          state_d = op_last_i ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (w_accept) begin
          opnd_d  = op_data_i;
          last_d  = op_last_i;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d[idx_q] = w_slice_s;
        carry_d      = w_slice_cout;
        if (idx_q == LAST_IDX) begin
`ifdef CLA_ADD_SEQ_OVF_EN
          ovf_d = ovf_q | w_slice_cout;
`endif
          state_d = last_q ? DONE : WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (sum_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
`ifdef CLA_ADD_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
`ifdef CLA_ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef CLA_ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_add_seq.sv
// ============================================================================
// tb_cla_add_seq : vector table + scoreboard bench for cla_add_seq
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_cla_add_seq;
  import cla_add_pkg::*;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        op_last;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic [3:0]  sum_count;
  logic        busy;
  logic        sum_ovf;

  cla_add_seq #(.WIDTH(32), .CNT_W(4)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_data_i   (op_data),
    .op_last_i   (op_last),
    .sum_valid_o (sum_valid),
    .sum_ready_i (sum_ready),
    .sum_data_o  (sum_data),
    .sum_count_o (sum_count),
    .busy_o      (busy)
`ifdef CLA_ADD_SEQ_OVF_EN
    ,
    .sum_ovf_o   (sum_ovf)
`endif
  );
`ifndef CLA_ADD_SEQ_OVF_EN
  assign sum_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] ops [5];
    logic [31:0] sum;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input vec_t v);
    logic [31:0] acc;
    logic [32:0] t;
    logic        ovf;
    acc = v.ops[0];
    ovf = 1'b0;
    for (int j = 1; j < v.n; j++) begin
      t   = {1'b0, acc} + {1'b0, v.ops[j]};
      ovf = ovf | t[32];
      acc = t[31:0];
    end
    return {ovf, acc};
  endfunction

  task automatic add_vec(input int n, input logic [31:0] a, b, c, d, e,
                         input logic [31:0] sum, input logic ovf);
    vec_t v;
    v.n = n;
    v.ops[0] = a; v.ops[1] = b; v.ops[2] = c; v.ops[3] = d; v.ops[4] = e;
    v.sum = sum;
    v.ovf = ovf;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] sat_cnt(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  // Scoreboard: compare each handed-off result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      check("sb_empty", 64'(sb.size() == 0), 64'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sum_data", 64'(sum_data), 64'(e.data));
        check("sum_count", 64'(sum_count), 64'(e.cnt));
`ifdef CLA_ADD_SEQ_OVF_EN
        check("sum_ovf", 64'(sum_ovf), 64'(e.ovf));
`endif
      end
    end
  end

  // Entered and left at posedge+1. With chk set, verifies ready/valid timing after the accept.
  task automatic send_op(input logic [31:0] d, input logic last, input int gap,
                         input bit chk, input bit first);
    int waitc = 0;
    op_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    op_valid = 1'b1;
    op_data  = d;
    op_last  = last;
    @(negedge clk);
    while (!op_ready && waitc < 100) begin @(negedge clk); waitc++; end
    check("accept_to", 64'(waitc >= 100), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_data  = $urandom;
    op_last  = 1'($urandom);
    if (chk) begin
      if (first) begin
        if (last) check("lat1_valid", 64'(sum_valid), 64'd1);
        else      check("first_wait_rdy", 64'(op_ready), 64'd1);
      end else begin
        for (int k = 0; k < NB; k++) begin
          @(negedge clk);
          check("add_rdy_low", 64'(op_ready), 64'd0);
          check("add_valid_low", 64'(sum_valid), 64'd0);
        end
        @(posedge clk); #1;
        if (last) check("latN_valid", 64'(sum_valid), 64'd1);
        else      check("wait_rdy", 64'(op_ready), 64'd1);
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 100) begin @(posedge clk); #1; c++; end
    check("idle_to", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    vec_t        tv;
    exp_t        e;

    rst = 1'b1; op_valid = 1'b0; op_data = '0; op_last = 1'b0; sum_ready = 1'b1;

    add_vec(1, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 1'b0);
    add_vec(2, 32'h000000FF, 32'h00000001, 0, 0, 0, 32'h00000100, 1'b0);
    add_vec(2, SHA256_H0[0], SHA256_H0[1], 0, 0, 0, 32'h257194EC, 1'b1);
    add_vec(5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'h0000000F, 1'b0);
    add_vec(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 0, 0, 32'h00000000, 1'b1);
    tv.n = 5;
    tv.ops[0] = SHA256_H0[7]; tv.ops[1] = SHA256_K[0]; tv.ops[2] = SHA256_H0[4];
    tv.ops[3] = SHA256_H0[5]; tv.ops[4] = SHA256_H0[6];
    m = model(tv);
    add_vec(5, tv.ops[0], tv.ops[1], tv.ops[2], tv.ops[3], tv.ops[4], m[31:0], m[32]);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(op_ready), 64'd1);
    check("rst_valid", 64'(sum_valid), 64'd0);
    check("rst_data", 64'(sum_data), 64'd0);
    check("rst_count", 64'(sum_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      e.data = vecs[i].sum;
      e.cnt  = sat_cnt(vecs[i].n);
      e.ovf  = vecs[i].ovf;
      for (int j = 0; j < vecs[i].n; j++) begin
        if (j == vecs[i].n - 1) sb.push_back(e);
        send_op(vecs[i].ops[j], j == vecs[i].n - 1, (i == 3) ? (j % 4) : 0, 1'b1, j == 0);
      end
      wait_idle();
    end

    // Result held in DONE while the consumer stalls.
    sum_ready = 1'b0;
    e.data = 32'hCAFEF00D; e.cnt = 4'd1; e.ovf = 1'b0;
    sb.push_back(e);
    send_op(32'hCAFEF00D, 1'b1, 0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(sum_valid), 64'd1);
      check("hold_data", 64'(sum_data), 64'hCAFEF00D);
      check("hold_ready", 64'(op_ready), 64'd0);
    end
    @(posedge clk); #1;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_busy", 64'(busy), 64'd0);
    check("handoff_valid", 64'(sum_valid), 64'd0);
    check("handoff_ready", 64'(op_ready), 64'd1);

    // Abort during ADD byte 2.
    send_op(32'h11111111, 1'b0, 0, 1'b0, 1'b1);
    send_op(32'h22222222, 1'b1, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 64'(op_ready), 64'd1);
    check("abort_valid", 64'(sum_valid), 64'd0);
    check("abort_data", 64'(sum_data), 64'd0);
    check("abort_count", 64'(sum_count), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(sum_ovf), 64'd0);
    rst = 1'b0;
    e.data = 32'h12345678; e.cnt = 4'd1; e.ovf = 1'b0;
    sb.push_back(e);
    send_op(32'h12345678, 1'b1, 0, 1'b1, 1'b1);
    wait_idle();

    // Count saturation: 17 operands, sum wraps, count stops at 15.
    e.data = 32'h10000000; e.cnt = 4'd15; e.ovf = 1'b1;
    for (int j = 0; j < 17; j++) begin
      if (j == 16) sb.push_back(e);
      send_op(32'h10000000, j == 16, 0, 1'b1, j == 0);
    end
    wait_idle();

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
